// File: rtl/spi_slave_fsm.sv
// SPI slave front end: deserialises {cmd, payload} frames from MOSI and
// serialises the RAM read byte back onto MISO. One SPI bit per clk edge.
module spi_slave_fsm #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int unsigned FrameW = DATA_W + 2;
  localparam int unsigned CntW   = $clog2(FrameW + 1);

  // Bit count of the last frame bit, and the count meaning "frame complete".
  localparam logic [CntW-1:0] CntLast = CntW'(FrameW - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FrameW);
  localparam logic [CntW-1:0] TxLast  = CntW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W:0]   shift_q, shift_d;
  logic [DATA_W+1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;
  logic              rd_addr_seen_q, rd_addr_seen_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [CntW-1:0]   tx_left_q, tx_left_d;
  logic              tx_busy_q, tx_busy_d;
  logic              tx_done_q, tx_done_d;

  logic frame_done;
  assign frame_done = (cnt_q == CntFull);

  // Next-state logic for frame reception, readback serialisation and abort.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = miso_q;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_shift_d     = tx_shift_q;
    tx_left_d      = tx_left_q;
    tx_busy_d      = tx_busy_q;
    tx_done_d      = tx_done_q;

    if (SS_n && (state_q != StIdle)) begin
      // Abort: drop the partial frame/readback, keep rd_addr_seen as is.
      state_d   = StIdle;
      cnt_d     = '0;
      miso_d    = 1'b0;
      tx_busy_d = 1'b0;
      tx_done_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!SS_n) begin
            state_d = StChkCmd;
            cnt_d   = '0;
          end
        end

        StChkCmd: begin
          shift_d   = {{DATA_W{1'b0}}, MOSI};
          cnt_d     = CntW'(1);
          tx_busy_d = 1'b0;
          tx_done_d = 1'b0;
          if (!MOSI) begin
            state_d = StWrite;
          end else if (rd_addr_seen_q) begin
            state_d = StReadData;
          end else begin
            state_d = StReadAdd;
          end
        end

        StWrite, StReadAdd, StReadData: begin
          if (!frame_done) begin
            shift_d = {shift_q[DATA_W-1:0], MOSI};
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
              rx_data_d  = {shift_q, MOSI};
              rx_valid_d = 1'b1;
              if (state_q == StReadAdd) begin
                rd_addr_seen_d = 1'b1;
              end
            end
          end else if (state_q == StReadData) begin
            if (tx_busy_q) begin
              if (tx_left_q != '0) begin
                miso_d     = tx_shift_q[DATA_W-1];
                tx_shift_d = tx_shift_q << 1;
                tx_left_d  = tx_left_q - CntW'(1);
              end else begin
                miso_d         = 1'b0;
                tx_busy_d      = 1'b0;
                tx_done_d      = 1'b1;
                rd_addr_seen_d = 1'b0;
              end
            end else if (!tx_done_q && tx_valid) begin
              // MSB goes out now; the rest follow on consecutive edges.
              miso_d     = tx_data[DATA_W-1];
              tx_shift_d = tx_data << 1;
              tx_left_d  = TxLast;
              tx_busy_d  = 1'b1;
            end
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_shift_q     <= '0;
      tx_left_q      <= '0;
      tx_busy_q      <= 1'b0;
      tx_done_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      miso_q         <= miso_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_shift_q     <= tx_shift_d;
      tx_left_q      <= tx_left_d;
      tx_busy_q      <= tx_busy_d;
      tx_done_q      <= tx_done_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
